// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - UART TX serializer (start/data/parity/stop), break generation under UART_TX_BREAK_EN
`timescale 1ns/1ps

module uart_tx_serializer #(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 BCLK,
    input  logic                 RST,
    input  logic                 ts_load,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 ts_shift,
`ifdef UART_TX_BREAK_EN
    input  logic                 break_en,
`endif
    output logic                 TX_OUT,
    output logic                 tsr_busy,
    output logic                 tsr_done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_PAR   = 3'd3,
        S_STOP  = 3'd4
`ifdef UART_TX_BREAK_EN
        ,
        S_BRK   = 3'd5
`endif
    } state_t;

    localparam logic [2:0] DATA_LAST  = 3'(DATA_BITS - 1);
    localparam logic [2:0] STOP_LAST  = 3'(STOP_BITS - 1);
    localparam bit         HAS_PARITY = (PARITY != 0);

    state_t               state;
    state_t               state_nxt;
    logic [2:0]           bit_cnt;
    logic [2:0]           bit_cnt_nxt;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] shreg_nxt;
    logic                 par_bit;
    logic                 par_bit_nxt;
    logic                 load_par;
    logic                 tx_nxt;
    logic                 busy_nxt;
    logic                 done_nxt;

    // Next-state, datapath and registered-output values; the line level is
    // derived from the state being entered so TX_OUT comes straight from a flop.
    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        shreg_nxt   = shreg;
        par_bit_nxt = par_bit;
        done_nxt    = 1'b0;
        tx_nxt      = 1'b1;
        busy_nxt    = 1'b0;

        // Odd parity makes the total count of ones odd, hence the XNOR.
        load_par = (PARITY == 1) ? ~^tx_data : ^tx_data;

        case (state)
            S_IDLE: begin
                // A shift strobe coinciding with the load is dropped so the
                // start bit always spans one full bit period.
                if (ts_load) begin
                    state_nxt   = S_START;
                    shreg_nxt   = tx_data;
                    par_bit_nxt = load_par;
                end
`ifdef UART_TX_BREAK_EN
                else if (break_en) begin
                    state_nxt = S_BRK;
                end
`endif
            end
            S_START: begin
                if (ts_shift) begin
                    state_nxt   = S_DATA;
                    bit_cnt_nxt = DATA_LAST;
                end
            end
            S_DATA: begin
                if (ts_shift) begin
                    shreg_nxt = {1'b1, shreg[DATA_BITS-1:1]};
                    if (bit_cnt == 3'd0) begin
                        if (HAS_PARITY) begin
                            state_nxt = S_PAR;
                        end else begin
                            state_nxt   = S_STOP;
                            bit_cnt_nxt = STOP_LAST;
                        end
                    end else begin
                        bit_cnt_nxt = bit_cnt - 3'd1;
                    end
                end
            end
            S_PAR: begin
                if (ts_shift) begin
                    state_nxt   = S_STOP;
                    bit_cnt_nxt = STOP_LAST;
                end
            end
            S_STOP: begin
                if (ts_shift) begin
                    if (bit_cnt == 3'd0) begin
                        state_nxt = S_IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        bit_cnt_nxt = bit_cnt - 3'd1;
                    end
                end
            end
`ifdef UART_TX_BREAK_EN
            S_BRK: begin
                if (!break_en) begin
                    state_nxt = S_IDLE;
                end
            end
`endif
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        case (state_nxt)
            S_IDLE:  tx_nxt = 1'b1;
            S_START: tx_nxt = 1'b0;
            S_DATA:  tx_nxt = shreg_nxt[0];
            S_PAR:   tx_nxt = par_bit_nxt;
            S_STOP:  tx_nxt = 1'b1;
`ifdef UART_TX_BREAK_EN
            S_BRK:   tx_nxt = 1'b0;
`endif
            default: tx_nxt = 1'b1;
        endcase

        busy_nxt = (state_nxt != S_IDLE);
    end

    // State, datapath and output registers with synchronous reset to idle line.
    always_ff @(posedge BCLK) begin
        if (RST) begin
            state    <= S_IDLE;
            bit_cnt  <= 3'd0;
            shreg    <= '1;
            par_bit  <= 1'b0;
            TX_OUT   <= 1'b1;
            tsr_busy <= 1'b0;
            tsr_done <= 1'b0;
        end else begin
            state    <= state_nxt;
            bit_cnt  <= bit_cnt_nxt;
            shreg    <= shreg_nxt;
            par_bit  <= par_bit_nxt;
            TX_OUT   <= tx_nxt;
            tsr_busy <= busy_nxt;
            tsr_done <= done_nxt;
        end
    end

endmodule

// File: doc/uart_tx_serializer.md
# uart_tx_serializer

Parametrised UART transmit serializer: accepts a parallel byte on a one-cycle load strobe and shifts out start, data (LSB first), optional parity and one or two stop bits, advancing one bit per `ts_shift` strobe from the baud generator. It sits between the transmit holding register / TX FIFO and the `TX_OUT` pin, in the `BCLK` domain. Relative to the fixed 10-bit shifter it adds:

- a data input instead of a hard-wired pattern;
- configurable word length, parity and stop-bit count;
- a completion pulse;
- optional break generation.

## Interface

Parameters:

- `DATA_BITS`, default 8: data word length, legal values 5–8.
- `PARITY`, default 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, default 1: legal values 1 or 2.

Ports:

- `BCLK` input 1: sole clock, all logic on the rising edge.
- `RST` input 1: synchronous, active-high reset.
- `ts_load` input 1: load strobe, one `BCLK` cycle.
- `tx_data` input `DATA_BITS`: word to send, sampled when the load is accepted.
- `ts_shift` input 1: bit-time strobe, one `BCLK` cycle per bit period.
- `break_en` input 1: break request, level-sensitive. Present only with `UART_TX_BREAK_EN`.
- `TX_OUT` output 1: serial line, idle high.
- `tsr_busy` output 1: frame or break in progress.
- `tsr_done` output 1: one-cycle pulse at frame completion.

## Operation

State machine with states IDLE, START, DATA, PAR, STOP and BRK.

- **Reset values:** `TX_OUT`=1, `tsr_busy`=0, `tsr_done`=0, state IDLE, bit counter 0, shift register all ones.
- **IDLE:** `TX_OUT`=1. When `ts_load`=1, capture `tx_data` into the shift register, compute parity, and go to START.
- **Parity computation:**
  - Even: parity bit = XOR of all data bits.
  - Odd: parity bit = XNOR of all data bits.
- **START:** `TX_OUT`=0. On `ts_shift`, go to DATA with the bit counter = `DATA_BITS`-1.
- **DATA:**
  - `TX_OUT` = shift register bit 0.
  - On `ts_shift`, shift right with 1 filled in at the MSB.
  - When the counter is 0, go to PAR if `PARITY`≠0, otherwise go to STOP.
  - Otherwise decrement the counter.
- **PAR:** `TX_OUT` = parity bit. On `ts_shift`, go to STOP with the counter = `STOP_BITS`-1.
- **STOP:** `TX_OUT`=1. On `ts_shift`:
  - counter 0: go to IDLE and pulse `tsr_done`;
  - otherwise decrement the counter.
- **Busy:** `tsr_busy`=1 in every state except IDLE.
- **`ts_load` while busy:** ignored. The frame in progress is not disturbed and `tx_data` is not re-sampled.
- **`ts_load` and `ts_shift` in the same IDLE cycle:** the load is accepted and the shift is discarded. The start bit lasts a full bit period, measured from the next `ts_shift`.
- **`ts_shift` in IDLE:** no effect.
- **Reset mid-frame:** the frame is aborted. At the next edge `TX_OUT`=1, `tsr_busy`=0 and no `tsr_done` is produced.
- **Frame length:** 1 + `DATA_BITS` + (`PARITY`≠0) + `STOP_BITS` `ts_shift` strobes from load to IDLE.

## Timing

- **Load to line:** the load is accepted at edge N. At N+1, `TX_OUT`=0 and `tsr_busy`=1. Latency is one `BCLK` cycle.
- **Bit transitions:** each bit changes on the edge after the `ts_shift` cycle. `TX_OUT` is registered and glitch-free.
- **`tsr_done`:** high for exactly the one cycle after the final stop-bit `ts_shift`. It coincides with `tsr_busy` falling.
- **Back-to-back frames:** `ts_load` in that same `tsr_done` cycle is accepted, because the block is IDLE. A new start bit follows with zero idle gap beyond the stop bits.
- **`ts_shift` spacing:** at least 2 `BCLK` cycles between strobes. Consecutive-cycle strobes are outside the contract.

## Configuration

Macro: `UART_TX_BREAK_EN`.

Defined:

- The `break_en` port and the BRK state exist.
- `break_en`=1 in IDLE with `ts_load`=0: go to BRK at the next edge. BRK drives `TX_OUT`=0 and `tsr_busy`=1.
- BRK persists while `break_en`=1. When `break_en` falls, return to IDLE at the next edge with `TX_OUT`=1 and `tsr_busy`=0, and no `tsr_done`.
- `break_en` raised mid-frame is deferred until the frame completes.
- `ts_load` wins over `break_en` in the same IDLE cycle.
- `ts_load` during BRK is ignored.

Undefined:

- The port and the BRK state are absent and no break logic is synthesised.

## Test plan

- **Basic frame:** defaults, `tx_data`=8'hA5, `ts_shift` every 16 cycles. `TX_OUT` bit sequence is 0,1,0,1,0,0,1,0,1,1. `tsr_busy` is high for 10 strobes and `tsr_done` pulses once.
- **Parity:** `PARITY`=2, `tx_data`=8'hA5 gives parity bit 0. `PARITY`=1 with the same data gives 1. `tx_data`=8'h07 with even parity gives 1. Check 11-bit frames.
- **Short word, two stops:** `DATA_BITS`=5, `STOP_BITS`=2, `tx_data`=5'h13 gives 0,1,1,0,0,1,1,1. The stop phase lasts 2 strobes.
- **Simultaneous and ignored inputs:**
  - `ts_load` and `ts_shift` in the same IDLE cycle: the start bit still spans one full strobe interval.
  - `ts_load`=8'h3C mid-frame: ignored, the current frame is unchanged.
  - `ts_load` during `tsr_done`: the next frame starts immediately.
- **Reset mid-frame:** `RST` after the 4th data bit. At the next edge `TX_OUT`=1 and `tsr_busy`=0, with no `tsr_done`. A later load of 8'h55 transmits a clean frame.
- **Break (`UART_TX_BREAK_EN`):**
  - `break_en` for 40 cycles from IDLE: `TX_OUT`=0 and `tsr_busy`=1 throughout, then idle 1 cycle after deassertion.
  - `break_en` raised mid-frame: the frame completes first, then the break starts.
